// File: rtl/nt_sig_pkg.sv
// Shared types and helpers for the Nt-node signature monitor: FSM state
// encoding, default MISR constants and the MISR next-state function.
package nt_sig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned DEF_SIG_W = 16;
  localparam logic [15:0] DEF_POLY  = 16'h8016;
  localparam logic [15:0] DEF_SEED  = 16'h0001;

  // Widest signature the helper supports; callers zero-extend into it.
  localparam int unsigned SIG_MAX = 64;

  // One MISR step on a w-bit signature held in the low bits of a SIG_MAX vector.
  function automatic logic [SIG_MAX-1:0] misr_next(
    input logic [SIG_MAX-1:0] sig,
    input logic [SIG_MAX-1:0] poly,
    input logic [SIG_MAX-1:0] d,
    input int unsigned        w
  );
    logic [SIG_MAX-1:0] mask;
    logic [SIG_MAX-1:0] nxt;
    mask = (w >= SIG_MAX) ? '1 : ((SIG_MAX'(1) << w) - SIG_MAX'(1));
    nxt  = (sig << 1) & mask;
    if (sig[w-1]) nxt = nxt ^ poly;
    return (nxt ^ d) & mask;
  endfunction

endpackage

// File: rtl/nt_misr.sv
// Signature register for the monitor: loads SEED on load, takes one MISR
// step on shift, clears on synchronous active-high reset.
module nt_misr
  import nt_sig_pkg::*;
#(
  parameter int unsigned      SIG_W = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [SIG_W-1:0] d,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_nxt;

  always_comb begin
    sig_nxt = SIG_W'(misr_next(SIG_MAX'(sig), SIG_MAX'(POLY), SIG_MAX'(d), SIG_W));
  end

  always_ff @(posedge clk) begin
    if (rst)        sig <= '0;
    else if (load)  sig <= SEED;
    else if (shift) sig <= sig_nxt;
  end

endmodule

// File: rtl/nt_node_signature_monitor.sv
// Capture-window monitor: MISR signature, toggle count and rare flag of an
// observed node. Define NT_SIG_SIDE_EN to fold side_in into the signature.
module nt_node_signature_monitor
  import nt_sig_pkg::*;
#(
  parameter int unsigned      SIG_W       = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY        = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED        = SIG_W'(DEF_SEED),
  parameter int unsigned      WINDOW_LEN  = 64,
  parameter int unsigned      RARE_THRESH = 2,
  parameter int unsigned      NSIDE       = 5,
  localparam int unsigned     CNT_W       = $clog2(WINDOW_LEN + 1)
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             start,
  input  logic             obs_in,
  input  logic [NSIDE-1:0] side_in,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SIG_W-1:0] sig_out,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             rare_flag
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] tog_nxt;
  logic             obs_q;
  logic             rare_q;
  logic             last_cap;
  logic             misr_load, misr_shift;
  logic [SIG_W-1:0] d;

`ifdef NT_SIG_SIDE_EN
  logic [NSIDE:0] d_raw;
  assign d_raw = {side_in, obs_in};
  assign d     = SIG_W'(d_raw);
`else
  logic unused_side;
  assign unused_side = ^side_in;
  assign d           = {{(SIG_W-1){1'b0}}, obs_in};
`endif

  assign last_cap = (wcnt == CNT_W'(WINDOW_LEN - 1));
  assign tog_nxt  = toggle_cnt + CNT_W'(obs_in != obs_q);

  always_comb begin
    state_d    = state_q;
    misr_load  = 1'b0;
    misr_shift = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = ARM;
      ARM: begin
        misr_load = 1'b1;
        state_d   = CAPTURE;
      end
      CAPTURE: begin
        misr_shift = 1'b1;
        if (last_cap) state_d = DONE;
      end
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state_q    <= IDLE;
      toggle_cnt <= '0;
      wcnt       <= '0;
      obs_q      <= 1'b0;
      rare_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ARM: begin
          toggle_cnt <= '0;
          wcnt       <= '0;
          obs_q      <= obs_in;
        end
        CAPTURE: begin
          toggle_cnt <= tog_nxt;
          obs_q      <= obs_in;
          wcnt       <= wcnt + CNT_W'(1);
          // Flag uses the count including this final cycle's toggle.
          if (last_cap) rare_q <= (32'(tog_nxt) <= RARE_THRESH);
        end
        DONE:    if (res_ready) rare_q <= 1'b0;
        default: ;
      endcase
    end
  end

  nt_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (I1470_clk),
    .rst   (I1477_rst),
    .load  (misr_load),
    .shift (misr_shift),
    .d     (d),
    .sig   (sig_out)
  );

  assign busy      = (state_q == ARM) || (state_q == CAPTURE);
  assign res_valid = (state_q == DONE);
  assign rare_flag = rare_q;

endmodule

// File: tb/tb_nt_node_signature_monitor.sv
// Directed bench for nt_node_signature_monitor: table of capture windows on a
// WINDOW_LEN=4 instance plus hand sequences and WINDOW_LEN=1/16 instances.
module tb_nt_node_signature_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       obs;
  logic [4:0] side;

  logic        start_a, ready_a, busy_a, valid_a, rare_a;
  logic [15:0] sig_a;
  logic [2:0]  tog_a;

  logic        start_b, ready_b, busy_b, valid_b, rare_b;
  logic [15:0] sig_b;
  logic [0:0]  tog_b;

  logic        start_c, ready_c, busy_c, valid_c, rare_c;
  logic [15:0] sig_c;
  logic [4:0]  tog_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nt_node_signature_monitor #(
    .SIG_W(16), .POLY(16'h8016), .SEED(16'h0001),
    .WINDOW_LEN(4), .RARE_THRESH(2), .NSIDE(5)
  ) dut_a (
    .I1470_clk(clk), .I1477_rst(rst), .start(start_a), .obs_in(obs), .side_in(side),
    .busy(busy_a), .res_valid(valid_a), .res_ready(ready_a),
    .sig_out(sig_a), .toggle_cnt(tog_a), .rare_flag(rare_a)
  );

  nt_node_signature_monitor #(
    .SIG_W(16), .POLY(16'h8016), .SEED(16'h0001),
    .WINDOW_LEN(1), .RARE_THRESH(2), .NSIDE(5)
  ) dut_b (
    .I1470_clk(clk), .I1477_rst(rst), .start(start_b), .obs_in(obs), .side_in(side),
    .busy(busy_b), .res_valid(valid_b), .res_ready(ready_b),
    .sig_out(sig_b), .toggle_cnt(tog_b), .rare_flag(rare_b)
  );

  nt_node_signature_monitor #(
    .SIG_W(16), .POLY(16'h8016), .SEED(16'h0001),
    .WINDOW_LEN(16), .RARE_THRESH(2), .NSIDE(5)
  ) dut_c (
    .I1470_clk(clk), .I1477_rst(rst), .start(start_c), .obs_in(obs), .side_in(side),
    .busy(busy_c), .res_valid(valid_c), .res_ready(ready_c),
    .sig_out(sig_c), .toggle_cnt(tog_c), .rare_flag(rare_c)
  );

  typedef struct {
    logic        obs_arm;
    logic [0:3]  seq;
    logic [15:0] sig;
    logic [2:0]  tog;
    logic        rare;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One rising edge; return at the following falling edge to sample/drive.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check({tag, ".arm_busy"}, 32'(busy_a), 32'd1);
    obs = v.obs_arm;
    step();
    for (int i = 0; i < 4; i++) begin
      obs = v.seq[i];
      if (i == 3) check({tag, ".valid_early"}, 32'(valid_a), 32'd0);
      step();
    end
    check({tag, ".valid"}, 32'(valid_a), 32'd1);
    check({tag, ".busy_done"}, 32'(busy_a), 32'd0);
    check({tag, ".sig"}, 32'(sig_a), 32'(v.sig));
    check({tag, ".tog"}, 32'(tog_a), 32'(v.tog));
    check({tag, ".rare"}, 32'(rare_a), 32'(v.rare));
    ready_a = 1'b1;
    step();
    ready_a = 1'b0;
    check({tag, ".idle_valid"}, 32'(valid_a), 32'd0);
    check({tag, ".idle_sig_hold"}, 32'(sig_a), 32'(v.sig));
    check({tag, ".idle_tog_hold"}, 32'(tog_a), 32'(v.tog));
    check({tag, ".idle_rare"}, 32'(rare_a), 32'd0);
  endtask

  initial begin
    vecs[0] = '{obs_arm: 1'b0, seq: 4'b0000, sig: 16'h0010, tog: 3'd0, rare: 1'b1};
    vecs[1] = '{obs_arm: 1'b0, seq: 4'b1010, sig: 16'h001A, tog: 3'd4, rare: 1'b0};
    vecs[2] = '{obs_arm: 1'b1, seq: 4'b1111, sig: 16'h001F, tog: 3'd0, rare: 1'b1};
    vecs[3] = '{obs_arm: 1'b0, seq: 4'b1100, sig: 16'h001C, tog: 3'd2, rare: 1'b1};
    vecs[4] = '{obs_arm: 1'b0, seq: 4'b1011, sig: 16'h001B, tog: 3'd3, rare: 1'b0};
    vecs[5] = '{obs_arm: 1'b1, seq: 4'b0000, sig: 16'h0010, tog: 3'd1, rare: 1'b1};

    rst = 1'b1; obs = 1'b0; side = '0;
    start_a = 1'b0; ready_a = 1'b0;
    start_b = 1'b0; ready_b = 1'b0;
    start_c = 1'b0; ready_c = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst.busy", 32'(busy_a), 32'd0);
    check("rst.valid", 32'(valid_a), 32'd0);
    check("rst.sig", 32'(sig_a), 32'd0);
    check("rst.tog", 32'(tog_a), 32'd0);
    check("rst.rare", 32'(rare_a), 32'd0);
    step();
    check("idle_no_start", 32'(busy_a), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Result held under backpressure; start in DONE is ignored.
    start_a = 1'b1; step(); start_a = 1'b0;
    obs = 1'b0; step();
    for (int i = 0; i < 4; i++) begin obs = vecs[1].seq[i]; step(); end
    for (int i = 0; i < 10; i++) begin
      start_a = i[0];
      step();
      check("hold.valid", 32'(valid_a), 32'd1);
      check("hold.sig", 32'(sig_a), 32'h001A);
      check("hold.tog", 32'(tog_a), 32'd4);
      check("hold.rare", 32'(rare_a), 32'd0);
    end
    start_a = 1'b1; ready_a = 1'b1;
    step();
    start_a = 1'b0; ready_a = 1'b0;
    check("accept.valid", 32'(valid_a), 32'd0);
    check("accept.busy", 32'(busy_a), 32'd0);
    step();
    check("accept.start_dropped", 32'(busy_a), 32'd0);

    // Reset during the second CAPTURE cycle discards the window.
    start_a = 1'b1; step(); start_a = 1'b0;
    obs = 1'b0; step();
    obs = 1'b1; step();
    check("abort.busy_before", 32'(busy_a), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("abort.busy", 32'(busy_a), 32'd0);
    check("abort.valid", 32'(valid_a), 32'd0);
    check("abort.sig", 32'(sig_a), 32'd0);
    check("abort.tog", 32'(tog_a), 32'd0);
    step();
    check("abort.stay_idle", 32'(busy_a), 32'd0);
    obs = 1'b0;
    run_vec(vecs[0], "after_abort");

`ifdef NT_SIG_SIDE_EN
    side = 5'b00001;
    run_vec('{obs_arm: 1'b0, seq: 4'b0000, sig: 16'h000E, tog: 3'd0, rare: 1'b1}, "side");
    side = '0;
`endif

    // Single-cycle window.
    start_b = 1'b1; step(); start_b = 1'b0;
    obs = 1'b0; step();
    obs = 1'b1; step();
    check("w1.valid", 32'(valid_b), 32'd1);
    check("w1.sig", 32'(sig_b), 32'h0003);
    check("w1.tog", 32'(tog_b), 32'd1);
    check("w1.rare", 32'(rare_b), 32'd1);
    ready_b = 1'b1; step(); ready_b = 1'b0;
    check("w1.idle", 32'(valid_b), 32'd0);

    // 16-cycle window shifts the seed through the MSB into the polynomial.
    obs = 1'b0;
    start_c = 1'b1; step(); start_c = 1'b0;
    step();
    for (int i = 0; i < 15; i++) step();
    check("w16.valid_early", 32'(valid_c), 32'd0);
    step();
    check("w16.valid", 32'(valid_c), 32'd1);
    check("w16.sig", 32'(sig_c), 32'h8016);
    check("w16.tog", 32'(tog_c), 32'd0);
    check("w16.rare", 32'(rare_c), 32'd1);
    ready_c = 1'b1; step(); ready_c = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
